idli_srf_m: RTL and testbench
=============================

IDLI_SRF_M -- requirements
Module: idli_srf_m

Interface
REQ-001 SHALL have parameter DATA_W, default 16, register width in bits.
REQ-002 SHALL have parameter DIGIT_W, default 4, bits moved per cycle; DATA_W SHALL be a multiple of DIGIT_W; DIGITS = DATA_W/DIGIT_W >= 2.
REQ-003 SHALL have parameter NUM_REGS, default 8, architectural register count (>= 2); RW = max(1, clog2(NUM_REGS)).
REQ-004 SHALL have parameter NUM_RD, default 2, number of read ports (>= 1).
REQ-005 SHALL have parameter ZERO_R0, default 1, 1 = R0 reads zero and discards writes.
REQ-006 SHALL have parameter PC_REG, default NUM_REGS-1, index served by the dedicated PC port.
REQ-007 i_srf_gck  in  1  clock; all state updates on rising edge.
REQ-008 i_srf_rst  in  1  reset; synchronous, active-high.
REQ-009 i_srf_start  in  1  request a DIGITS-cycle word pass.
REQ-010 o_srf_busy  out  1  pass in progress (state RUN).
REQ-011 o_srf_phase  out  clog2(DIGITS)  index of digit currently presented.
REQ-012 o_srf_last  out  1  final digit of the pass (RUN and phase == DIGITS-1).
REQ-013 o_srf_err  out  1  sticky: start seen mid-pass.
REQ-014 i_srf_rd_reg  in  NUM_RD*RW  read selects; port k at [k*RW +: RW].
REQ-015 o_srf_rd_data  out  NUM_RD*DIGIT_W  read digits; port k at [k*DIGIT_W +: DIGIT_W].
REQ-016 i_srf_wr_reg, i_srf_wr_vld, i_srf_wr_data  in  RW, 1, DIGIT_W  general write port.
REQ-017 i_srf_pc_vld, i_srf_pc_data  in  1, DIGIT_W; o_srf_pc_data  out  DIGIT_W  PC port.

Function
REQ-018 Each register SHALL store DATA_W bits; the presented digit is bits [DIGIT_W-1:0]; with ZERO_R0=1 no storage SHALL exist for R0.
REQ-019 States SHALL be IDLE and RUN; IDLE -> RUN on i_srf_start; RUN -> IDLE after the last digit unless i_srf_start is high during o_srf_last (back-to-back pass, phase wraps to 0, stays RUN).
REQ-020 In RUN every register SHALL rotate right by DIGIT_W each cycle, incoming digit entering [DATA_W-1:DATA_W-DIGIT_W]; phase SHALL increment, wrapping DIGITS-1 -> 0.
REQ-021 In IDLE registers SHALL hold, phase SHALL be 0, writes SHALL be ignored; reads still present digit 0 combinationally.
REQ-022 Incoming digit SHALL default to the current digit (pure rotate); if register == PC_REG and i_srf_pc_vld, it SHALL be i_srf_pc_data; if i_srf_wr_vld and i_srf_wr_reg matches, it SHALL be i_srf_wr_data (general port wins over PC port).
REQ-023 Read data SHALL be combinational from current stored digit (no write bypass); select of R0 (ZERO_R0=1) or index >= NUM_REGS SHALL return 0; writes to those indices SHALL be discarded.
REQ-024 o_srf_pc_data SHALL equal the current digit of PC_REG.
REQ-025 After DIGITS RUN cycles every register SHALL be back at original alignment, holding any digits written.
REQ-026 i_srf_start in RUN other than on the last digit SHALL be ignored for sequencing and SHALL set o_srf_err until reset.
REQ-027 Latency: digit written at phase p SHALL be readable at phase p of the next pass, never earlier.

Reset
REQ-028 i_srf_rst SHALL, at the next edge, clear all registers to 0, state to IDLE, phase to 0, o_srf_err to 0; overrides start and writes.
REQ-029 Reset mid-pass SHALL abandon the pass; partially written words SHALL read 0 afterwards.
REQ-030 Out of reset: o_srf_busy=0, o_srf_last=0, o_srf_phase=0, all read data 0.

Verification
REQ-031 Defaults: start one pass, write R3 digits 4,3,2,1 at phases 0..3 -> next pass read R3 yields 4,3,2,1; o_srf_last high only at phase 3.
REQ-032 Same cycle wr_reg=7 data 0xA and pc_vld data 0x5 for all digits -> PC reads 0xAAAA next pass.
REQ-033 Write 0xF to R0 every digit -> R0 reads 0 on all ports; other registers unchanged.
REQ-034 Start held through two passes -> busy stays 1, phase 0,1,2,3,0,1,2,3, then IDLE; start pulse at phase 1 -> o_srf_err=1, pass still ends after phase 3.
REQ-035 Load R1=0x1234, reset at phase 2 -> R1 reads 0, busy 0, err 0.
REQ-036 DATA_W=8, DIGIT_W=2, NUM_REGS=4, NUM_RD=3, ZERO_R0=0 -> 4-cycle passes, R0 writable, all three ports return correct digits.

Source files
------------

// File: rtl/idli_srf_m.sv
// Bit-serial register file: every register rotates right by one digit per RUN cycle,
// so a full word pass takes DIGITS cycles and reads/writes touch only the low digit.
module idli_srf_m #(
   parameter int unsigned DATA_W   = 16,
   parameter int unsigned DIGIT_W  = 4,
   parameter int unsigned NUM_REGS = 8,
   parameter int unsigned NUM_RD   = 2,
   parameter int unsigned ZERO_R0  = 1,
   parameter int unsigned PC_REG   = NUM_REGS - 1,
   localparam int unsigned RW      = ($clog2(NUM_REGS) > 1) ? $clog2(NUM_REGS) : 1,
   localparam int unsigned DIGITS  = DATA_W / DIGIT_W,
   localparam int unsigned PH_W    = $clog2(DIGITS)
) (
   input  logic                        i_srf_gck,
   input  logic                        i_srf_rst,
   input  logic                        i_srf_start,
   output logic                        o_srf_busy,
   output logic [PH_W-1:0]             o_srf_phase,
   output logic                        o_srf_last,
   output logic                        o_srf_err,
   input  logic [NUM_RD*RW-1:0]        i_srf_rd_reg,
   output logic [NUM_RD*DIGIT_W-1:0]   o_srf_rd_data,
   input  logic [RW-1:0]               i_srf_wr_reg,
   input  logic                        i_srf_wr_vld,
   input  logic [DIGIT_W-1:0]          i_srf_wr_data,
   input  logic                        i_srf_pc_vld,
   input  logic [DIGIT_W-1:0]          i_srf_pc_data,
   output logic [DIGIT_W-1:0]          o_srf_pc_data
);

   typedef enum logic {StIdle, StRun} state_e;

   state_e              r_state, w_state_nxt;
   logic [PH_W-1:0]     r_phase, w_phase_nxt;
   logic                r_err, w_err_nxt;
   logic                w_run, w_last;
   logic [DIGIT_W-1:0]  w_cur [NUM_REGS];

   assign w_run  = (r_state == StRun);
   assign w_last = w_run && (r_phase == PH_W'(DIGITS - 1));

   always_ff @(posedge i_srf_gck) begin
      if (i_srf_rst) begin
         r_state <= StIdle;
         r_phase <= '0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_phase <= w_phase_nxt;
         r_err   <= w_err_nxt;
      end
   end

   // A start on the last digit chains straight into the next pass.
   always_comb begin
      w_state_nxt = r_state;
      w_phase_nxt = r_phase;
      w_err_nxt   = r_err;
      unique case (r_state)
         StIdle: begin
            w_phase_nxt = '0;
            if (i_srf_start) w_state_nxt = StRun;
         end
         StRun: begin
            if (w_last) begin
               w_phase_nxt = '0;
               if (!i_srf_start) w_state_nxt = StIdle;
            end else begin
               w_phase_nxt = r_phase + PH_W'(1);
               if (i_srf_start) w_err_nxt = 1'b1;
            end
         end
         default: w_state_nxt = StIdle;
      endcase
   end

   for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg
      if (ZERO_R0 != 0 && g == 0) begin : g_zero
         assign w_cur[g] = '0;
      end else begin : g_store
         localparam bit IS_PC = (g == PC_REG);
         logic [DATA_W-1:0]  r_word;
         logic [DIGIT_W-1:0] w_in;

         // General write port takes priority over the PC port.
         always_comb begin
            w_in = r_word[DIGIT_W-1:0];
            if (IS_PC && i_srf_pc_vld) w_in = i_srf_pc_data;
            if (i_srf_wr_vld && (i_srf_wr_reg == RW'(g))) w_in = i_srf_wr_data;
         end

         always_ff @(posedge i_srf_gck) begin
            if (i_srf_rst) begin
               r_word <= '0;
            end else if (w_run) begin
               r_word <= {w_in, r_word[DATA_W-1:DIGIT_W]};
            end
         end

         assign w_cur[g] = r_word[DIGIT_W-1:0];
      end
   end

   // Out-of-range selects match no register and fall through to zero.
   always_comb begin
      o_srf_rd_data = '0;
      for (int k = 0; k < NUM_RD; k++) begin
         for (int j = 0; j < NUM_REGS; j++) begin
            if (i_srf_rd_reg[k*RW +: RW] == RW'(j)) begin
               o_srf_rd_data[k*DIGIT_W +: DIGIT_W] = w_cur[j];
            end
         end
      end
   end

   assign o_srf_pc_data = w_cur[PC_REG];
   assign o_srf_busy    = w_run;
   assign o_srf_phase   = r_phase;
   assign o_srf_last    = w_last;
   assign o_srf_err     = r_err;

endmodule

// File: tb/tb_idli_srf_m.sv
// Bench for idli_srf_m: default instance driven by a vector table, hand sequences and a
// model-fed scoreboard; a second small instance checks the narrow 3-port configuration.
module tb_idli_srf_m;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst, start, wr_vld, pc_vld;
   logic [5:0] rd_reg;
   logic [2:0] wr_reg;
   logic [3:0] wr_data, pc_data, pc_out;
   logic       busy, last, err;
   logic [1:0] phase;
   logic [7:0] rd_data;

   logic       start_b, wr_vld_b, pc_vld_b, busy_b, last_b, err_b;
   logic [5:0] rd_reg_b, rd_data_b;
   logic [1:0] wr_reg_b, wr_data_b, pc_data_b, pc_out_b, phase_b;

   idli_srf_m u_dut (
      .i_srf_gck(clk), .i_srf_rst(rst), .i_srf_start(start),
      .o_srf_busy(busy), .o_srf_phase(phase), .o_srf_last(last), .o_srf_err(err),
      .i_srf_rd_reg(rd_reg), .o_srf_rd_data(rd_data),
      .i_srf_wr_reg(wr_reg), .i_srf_wr_vld(wr_vld), .i_srf_wr_data(wr_data),
      .i_srf_pc_vld(pc_vld), .i_srf_pc_data(pc_data), .o_srf_pc_data(pc_out)
   );

   idli_srf_m #(.DATA_W(8), .DIGIT_W(2), .NUM_REGS(4), .NUM_RD(3), .ZERO_R0(0)) u_dut_b (
      .i_srf_gck(clk), .i_srf_rst(rst), .i_srf_start(start_b),
      .o_srf_busy(busy_b), .o_srf_phase(phase_b), .o_srf_last(last_b), .o_srf_err(err_b),
      .i_srf_rd_reg(rd_reg_b), .o_srf_rd_data(rd_data_b),
      .i_srf_wr_reg(wr_reg_b), .i_srf_wr_vld(wr_vld_b), .i_srf_wr_data(wr_data_b),
      .i_srf_pc_vld(pc_vld_b), .i_srf_pc_data(pc_data_b), .o_srf_pc_data(pc_out_b)
   );

   typedef struct {
      logic       start;
      logic       wr_vld;
      logic [2:0] wr_reg;
      logic [3:0] wr_data;
      logic [2:0] rd0, rd1;
      logic       e_busy;
      logic [1:0] e_phase;
      logic       e_last;
      logic [3:0] e_rd0, e_rd1;
   } vec_t;

   vec_t       tbl [10];
   logic [3:0] sb_q [$];
   logic [15:0] mdl [8];
   logic [1:0] d0 [4];
   logic [1:0] d2 [4];
   int n_tests = 0;
   int n_fail  = 0;

   function automatic vec_t mk(logic s, logic wv, logic [2:0] wr, logic [3:0] wd,
                               logic [2:0] a, logic [2:0] b, logic eb, logic [1:0] ep,
                               logic el, logic [3:0] e0, logic [3:0] e1);
      vec_t v;
      v.start = s; v.wr_vld = wv; v.wr_reg = wr; v.wr_data = wd; v.rd0 = a; v.rd1 = b;
      v.e_busy = eb; v.e_phase = ep; v.e_last = el; v.e_rd0 = e0; v.e_rd1 = e1;
      return v;
   endfunction

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   task automatic sb_check(input string nm, input logic [3:0] act);
      logic [3:0] exp;
      if (sb_q.size() == 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL %s: got %0h, expected entry missing from scoreboard", nm, act);
      end else begin
         exp = sb_q.pop_front();
         check(nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic idle_in();
      start = 1'b0; wr_vld = 1'b0; pc_vld = 1'b0;
      wr_reg = '0; wr_data = '0; pc_data = '0; rd_reg = '0;
   endtask

   task automatic set_rd(input logic [2:0] a, input logic [2:0] b);
      rd_reg = {b, a};
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at time limit, expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      idle_in();
      start_b = 1'b0; wr_vld_b = 1'b0; pc_vld_b = 1'b0;
      rd_reg_b = '0; wr_reg_b = '0; wr_data_b = '0; pc_data_b = '0;
      d0 = '{2'd1, 2'd2, 2'd3, 2'd1};
      d2 = '{2'd3, 2'd0, 2'd2, 2'd1};
      for (int r = 0; r < 8; r++) mdl[r] = '0;

      // R3 <- 4,3,2,1 in pass one; read back in a chained second pass
      tbl[0] = mk(1, 0, 0, 0, 3, 0, 0, 0, 0, 0, 0);
      tbl[1] = mk(0, 1, 3, 4, 3, 7, 1, 0, 0, 0, 0);
      tbl[2] = mk(0, 1, 3, 3, 3, 7, 1, 1, 0, 0, 0);
      tbl[3] = mk(0, 1, 3, 2, 3, 7, 1, 2, 0, 0, 0);
      tbl[4] = mk(1, 1, 3, 1, 3, 7, 1, 3, 1, 0, 0);
      tbl[5] = mk(0, 0, 0, 0, 3, 0, 1, 0, 0, 4, 0);
      tbl[6] = mk(0, 0, 0, 0, 3, 0, 1, 1, 0, 3, 0);
      tbl[7] = mk(0, 0, 0, 0, 3, 0, 1, 2, 0, 2, 0);
      tbl[8] = mk(0, 0, 0, 0, 3, 0, 1, 3, 1, 1, 0);
      tbl[9] = mk(0, 0, 0, 0, 3, 3, 0, 0, 0, 4, 4);

      rst = 1'b1;
      @(negedge clk);
      tick();
      rst = 1'b0;
      set_rd(3, 7);
      #1;
      check("reset busy", busy, 0);
      check("reset phase", phase, 0);
      check("reset last", last, 0);
      check("reset err", err, 0);
      check("reset rd", rd_data, 0);
      check("reset pc", pc_out, 0);
      check("reset b busy", busy_b, 0);
      check("reset b rd", rd_data_b, 0);
      tick();

      for (int i = 0; i < 10; i++) begin
         start = tbl[i].start; wr_vld = tbl[i].wr_vld;
         wr_reg = tbl[i].wr_reg; wr_data = tbl[i].wr_data;
         set_rd(tbl[i].rd0, tbl[i].rd1);
         #1;
         check($sformatf("vec%0d busy", i), busy, tbl[i].e_busy);
         check($sformatf("vec%0d phase", i), phase, tbl[i].e_phase);
         check($sformatf("vec%0d last", i), last, tbl[i].e_last);
         check($sformatf("vec%0d rd0", i), rd_data[3:0], tbl[i].e_rd0);
         check($sformatf("vec%0d rd1", i), rd_data[7:4], tbl[i].e_rd1);
         tick();
      end
      check("chain err", err, 0);

      // General write to PC register beats PC port in the same cycle
      idle_in(); start = 1'b1; tick();
      for (int p = 0; p < 4; p++) begin
         start = (p == 3); wr_vld = 1'b1; wr_reg = 3'd7; wr_data = 4'hA;
         pc_vld = 1'b1; pc_data = 4'h5; set_rd(7, 7);
         #1;
         check($sformatf("pcw p%0d no bypass", p), rd_data[3:0], 0);
         check($sformatf("pcw p%0d pc old", p), pc_out, 0);
         tick();
      end
      for (int p = 0; p < 4; p++) begin
         idle_in(); set_rd(7, 3);
         sb_q.push_back(4'hA); sb_q.push_back(4'(4 - p)); sb_q.push_back(4'hA);
         #1;
         sb_check($sformatf("pcr p%0d rd R7", p), rd_data[3:0]);
         sb_check($sformatf("pcr p%0d rd R3", p), rd_data[7:4]);
         sb_check($sformatf("pcr p%0d pc", p), pc_out);
         tick();
      end

      // Writes to R0 are dropped, other registers untouched
      idle_in(); start = 1'b1; tick();
      for (int p = 0; p < 4; p++) begin
         start = (p == 3); wr_vld = 1'b1; wr_reg = 3'd0; wr_data = 4'hF; set_rd(0, 0);
         #1;
         tick();
      end
      for (int p = 0; p < 4; p++) begin
         idle_in(); set_rd(0, 3);
         #1;
         check($sformatf("r0 p%0d port0", p), rd_data[3:0], 0);
         check($sformatf("r0 p%0d R3", p), rd_data[7:4], 4 - p);
         check($sformatf("r0 p%0d pc", p), pc_out, 4'hA);
         set_rd(3, 0);
         #1;
         check($sformatf("r0 p%0d port1", p), rd_data[7:4], 0);
         tick();
      end

      // Start held across two passes
      idle_in(); start = 1'b1;
      #1;
      check("hold idle busy", busy, 0);
      tick();
      for (int k = 0; k < 8; k++) begin
         start = (k != 7);
         #1;
         check($sformatf("hold k%0d busy", k), busy, 1);
         check($sformatf("hold k%0d phase", k), phase, k % 4);
         check($sformatf("hold k%0d last", k), last, (k % 4) == 3);
         tick();
      end
      start = 1'b0;
      #1;
      check("hold end busy", busy, 0);
      check("hold end phase", phase, 0);
      check("hold err sticky", err, 1);
      rst = 1'b1; tick(); rst = 1'b0;
      #1;
      check("rst clears err", err, 0);

      // Mid-pass start pulse: flagged, sequencing unchanged
      start = 1'b1; tick();
      start = 1'b0; tick();
      start = 1'b1;
      #1;
      check("pulse phase", phase, 1);
      check("pulse err before edge", err, 0);
      tick();
      start = 1'b0;
      #1;
      check("pulse err", err, 1);
      check("pulse phase2", phase, 2);
      tick();
      #1;
      check("pulse last", last, 1);
      tick();
      #1;
      check("pulse ends busy", busy, 0);
      check("pulse err held", err, 1);

      // Reset mid-pass abandons it and clears partial words
      rst = 1'b1; tick(); rst = 1'b0;
      start = 1'b1; tick();
      for (int p = 0; p < 4; p++) begin
         start = (p == 3); wr_vld = 1'b1; wr_reg = 3'd1; wr_data = 4'(4 - p);
         #1;
         tick();
      end
      idle_in(); set_rd(1, 1);
      #1;
      check("r1 p0", rd_data[3:0], 4);
      tick();
      start = 1'b1; wr_vld = 1'b1; wr_reg = 3'd2; wr_data = 4'h9;
      #1;
      check("r1 p1", rd_data[3:0], 3);
      tick();
      #1;
      check("r1 mid err", err, 1);
      rst = 1'b1; wr_reg = 3'd1; wr_data = 4'hF;
      tick();
      rst = 1'b0; idle_in(); set_rd(1, 2);
      #1;
      check("mrst busy", busy, 0);
      check("mrst phase", phase, 0);
      check("mrst err", err, 0);
      check("mrst last", last, 0);
      start = 1'b1;
      tick();
      for (int p = 0; p < 4; p++) begin
         start = 1'b0;
         #1;
         check($sformatf("mrst p%0d R1", p), rd_data[3:0], 0);
         check($sformatf("mrst p%0d R2", p), rd_data[7:4], 0);
         tick();
      end

      // Random traffic against a word-level model
      idle_in(); start = 1'b1; tick();
      for (int ps = 0; ps < 6; ps++) begin
         for (int p = 0; p < 4; p++) begin
            logic [2:0] a, b;
            logic [3:0] inc;
            wr_vld = 1'($urandom_range(0, 1)); wr_reg = 3'($urandom_range(0, 7));
            wr_data = 4'($urandom_range(0, 15));
            pc_vld = 1'($urandom_range(0, 1)); pc_data = 4'($urandom_range(0, 15));
            a = 3'($urandom_range(0, 7)); b = 3'($urandom_range(0, 7));
            start = (p == 3) && (ps != 5);
            set_rd(a, b);
            sb_q.push_back(mdl[a][p*4 +: 4]);
            sb_q.push_back(mdl[b][p*4 +: 4]);
            sb_q.push_back(mdl[7][p*4 +: 4]);
            #1;
            check($sformatf("rnd s%0d p%0d phase", ps, p), phase, p);
            sb_check($sformatf("rnd s%0d p%0d rd0", ps, p), rd_data[3:0]);
            sb_check($sformatf("rnd s%0d p%0d rd1", ps, p), rd_data[7:4]);
            sb_check($sformatf("rnd s%0d p%0d pc", ps, p), pc_out);
            for (int r = 1; r < 8; r++) begin
               inc = mdl[r][p*4 +: 4];
               if (r == 7 && pc_vld) inc = pc_data;
               if (wr_vld && wr_reg == 3'(r)) inc = wr_data;
               mdl[r][p*4 +: 4] = inc;
            end
            tick();
         end
      end
      idle_in();
      #1;
      check("rnd end busy", busy, 0);

      // Narrow configuration: R0 writable, three read ports
      start_b = 1'b1; tick();
      for (int p = 0; p < 4; p++) begin
         start_b = (p == 3); wr_vld_b = 1'b1; wr_reg_b = 2'd0; wr_data_b = d0[p];
         rd_reg_b = {2'd3, 2'd2, 2'd1};
         #1;
         check($sformatf("b1 p%0d busy", p), busy_b, 1);
         check($sformatf("b1 p%0d phase", p), phase_b, p);
         tick();
      end
      for (int p = 0; p < 4; p++) begin
         start_b = (p == 3); wr_vld_b = 1'b1; wr_reg_b = 2'd2; wr_data_b = d2[p];
         rd_reg_b = {2'd2, 2'd1, 2'd0};
         #1;
         check($sformatf("b2 p%0d R0", p), rd_data_b[1:0], d0[p]);
         check($sformatf("b2 p%0d R1", p), rd_data_b[3:2], 0);
         check($sformatf("b2 p%0d R2 old", p), rd_data_b[5:4], 0);
         tick();
      end
      for (int p = 0; p < 4; p++) begin
         start_b = 1'b0; wr_vld_b = 1'b0;
         rd_reg_b = {2'd3, 2'd0, 2'd2};
         #1;
         check($sformatf("b3 p%0d R2", p), rd_data_b[1:0], d2[p]);
         check($sformatf("b3 p%0d R0", p), rd_data_b[3:2], d0[p]);
         check($sformatf("b3 p%0d R3", p), rd_data_b[5:4], 0);
         check($sformatf("b3 p%0d last", p), last_b, p == 3);
         tick();
      end
      #1;
      check("b end busy", busy_b, 0);
      check("b err", err_b, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
